// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline widths, control-bundle bit positions and the ID/EX payload struct.
package riscv_pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 9;
    localparam int unsigned REG_W  = 5;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_REGWRITE = 8;
    localparam int unsigned CTRL_MEMREAD  = 7;
    localparam int unsigned CTRL_MEMWRITE = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_BRANCH   = 3;
    localparam int unsigned CTRL_JUMP     = 2;
    localparam int unsigned CTRL_ALUOP_HI = 1;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [REG_W-1:0]  REG_X0   = 5'd0;

    // Everything that travels from ID into EX; an all-zero value is a bubble
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side, write-back and EX-side signals of the ID/EX pipeline register.
interface id_ex_pipe_reg_if;
    import riscv_pipe_pkg::*;

    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic [2:0]        id_funct3;
    logic              id_funct7b5;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_W-1:0]  ex_rs1;
    logic [REG_W-1:0]  ex_rs2;
    logic [REG_W-1:0]  ex_rd;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic [CTRL_W-1:0] ex_ctrl;

    // Pipeline control / decode side: drives ID and WB, observes EX
    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_ctrl,
               wb_we, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_ctrl
    );

    // The pipeline register itself
    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_ctrl,
               wb_we, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_ctrl
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualified events, holding once the maximum is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, WB refresh of held operands and perf counters.
module id_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_pipe_reg_if.slave   bus,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
);

    id_ex_t ex_q;
    id_ex_t id_c;
    logic   wb_fwd_c;
    logic   rs1_hit_c;
    logic   rs2_hit_c;
    logic   bubble_c;
    logic   hold_c;

    // Gather the ID-side fields into one payload
    assign id_c = '{
        valid:    1'b1,
        pc:       bus.id_pc,
        rs1_data: bus.id_rs1_data,
        rs2_data: bus.id_rs2_data,
        imm:      bus.id_imm,
        rs1:      bus.id_rs1,
        rs2:      bus.id_rs2,
        rd:       bus.id_rd,
        funct3:   bus.id_funct3,
        funct7b5: bus.id_funct7b5,
        ctrl:     bus.id_ctrl
    };

    // A held operand is refreshed only by a real write to a non-x0 register it names
    assign wb_fwd_c  = bus.wb_we && (bus.wb_rd != REG_X0) && ex_q.valid;
    assign rs1_hit_c = wb_fwd_c && (bus.wb_rd == ex_q.rs1);
    assign rs2_hit_c = wb_fwd_c && (bus.wb_rd == ex_q.rs2);

    // Flush beats stall; an unstalled load of an empty ID slot is also a bubble
    assign bubble_c = bus.flush || (!bus.stall && !bus.id_valid);
    assign hold_c   = bus.stall && !bus.flush;

    // Pipeline register: bubble, hold-with-refresh, or capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bubble_c) begin
            ex_q <= '0;
        end else if (hold_c) begin
            if (rs1_hit_c) ex_q.rs1_data <= bus.wb_data;
            if (rs2_hit_c) ex_q.rs2_data <= bus.wb_data;
        end else begin
            ex_q <= id_c;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_funct7b5 = ex_q.funct7b5;
    assign bus.ex_ctrl     = ex_q.ctrl;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hold_c),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_c),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: per-cycle reference model plus literal spot checks.
module tb_id_ex_pipe_reg;
    import riscv_pipe_pkg::*;

    localparam int unsigned CW  = 4;
    localparam int          SAT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] bubble_count;

    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what EX must hold after each edge
    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [8:0]  m_ctrl;
    int          m_stalls, m_bubbles;

    task automatic model_clear();
        m_valid <= 0; m_pc <= 0; m_d1 <= 0; m_d2 <= 0; m_imm <= 0;
        m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_f3 <= 0; m_f7 <= 0; m_ctrl <= 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear();
            m_stalls  <= 0;
            m_bubbles <= 0;
        end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
            model_clear();
            m_bubbles <= (m_bubbles < SAT) ? m_bubbles + 1 : SAT;
        end else if (bus.stall) begin
            m_stalls <= (m_stalls < SAT) ? m_stalls + 1 : SAT;
            if (bus.wb_we && bus.wb_rd != 0 && m_valid) begin
                if (bus.wb_rd == m_rs1) m_d1 <= bus.wb_data;
                if (bus.wb_rd == m_rs2) m_d2 <= bus.wb_data;
            end
        end else begin
            m_valid <= 1;           m_pc <= bus.id_pc;
            m_d1 <= bus.id_rs1_data; m_d2 <= bus.id_rs2_data;
            m_imm <= bus.id_imm;     m_rs1 <= bus.id_rs1;
            m_rs2 <= bus.id_rs2;     m_rd <= bus.id_rd;
            m_f3 <= bus.id_funct3;   m_f7 <= bus.id_funct7b5;
            m_ctrl <= bus.id_ctrl;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid",   64'(bus.ex_valid),    64'(m_valid));
            chk("m_pc",      64'(bus.ex_pc),       64'(m_pc));
            chk("m_rs1_data",64'(bus.ex_rs1_data), 64'(m_d1));
            chk("m_rs2_data",64'(bus.ex_rs2_data), 64'(m_d2));
            chk("m_imm",     64'(bus.ex_imm),      64'(m_imm));
            chk("m_rs1",     64'(bus.ex_rs1),      64'(m_rs1));
            chk("m_rs2",     64'(bus.ex_rs2),      64'(m_rs2));
            chk("m_rd",      64'(bus.ex_rd),       64'(m_rd));
            chk("m_funct3",  64'(bus.ex_funct3),   64'(m_f3));
            chk("m_funct7b5",64'(bus.ex_funct7b5), 64'(m_f7));
            chk("m_ctrl",    64'(bus.ex_ctrl),     64'(m_ctrl));
            chk("m_stall_count",  64'(stall_count),  64'(m_stalls));
            chk("m_bubble_count", 64'(bubble_count), 64'(m_bubbles));
        end
    end

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [8:0] ctrl);
        bus.id_valid = v;    bus.id_pc = pc;
        bus.id_rs1 = rs1;    bus.id_rs1_data = d1;
        bus.id_rs2 = rs2;    bus.id_rs2_data = d2;
        bus.id_rd = rd;      bus.id_ctrl = ctrl;
        bus.id_imm = pc + 32'h100;
        bus.id_funct3 = pc[4:2];
        bus.id_funct7b5 = pc[2];
    endtask

    initial begin
        bus.stall = 0; bus.flush = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        #2 rst = 1;
        #1;
        chk("reset_valid",  64'(bus.ex_valid), 64'd0);
        chk("reset_pc",     64'(bus.ex_pc),    64'd0);
        chk("reset_ctrl",   64'(bus.ex_ctrl),  64'd0);
        chk("reset_stalls", 64'(stall_count),  64'd0);
        chk("reset_bubbles",64'(bubble_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        cmp_en = 1;

        // Load after reset
        set_id(1, 32'h40, 5'd3, 32'h11, 5'd4, 32'h22, 5'd5, 9'h1FF);
        #1;
        chk("pre_edge_pc",    64'(bus.ex_pc),    64'd0);
        chk("pre_edge_valid", 64'(bus.ex_valid), 64'd0);
        @(negedge clk);
        chk("load_pc",    64'(bus.ex_pc),    64'h40);
        chk("load_rd",    64'(bus.ex_rd),    64'd5);
        chk("load_ctrl",  64'(bus.ex_ctrl),  64'h1FF);
        chk("load_valid", 64'(bus.ex_valid), 64'd1);
        chk("load_imm",   64'(bus.ex_imm),   64'h140);

        // Stall with refresh of rs1 only
        bus.stall = 1; bus.wb_we = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAB;
        set_id(1, 32'h99, 5'd9, 32'h999, 5'd9, 32'h999, 5'd9, 9'h0AA);
        @(negedge clk);
        chk("refresh_rs1",  64'(bus.ex_rs1_data), 64'hAB);
        chk("hold_rs2",     64'(bus.ex_rs2_data), 64'h22);
        chk("hold_pc",      64'(bus.ex_pc),       64'h40);
        chk("stall_cnt_1",  64'(stall_count),     64'd1);

        // wb_rd = x0 never refreshes
        bus.wb_rd = 5'd0; bus.wb_data = 32'hCD;
        @(negedge clk);
        chk("wb_x0_hold", 64'(bus.ex_rs1_data), 64'hAB);

        // ex_rs1 = x0 with wb_rd = x0: no refresh
        bus.stall = 0; bus.wb_we = 0;
        set_id(1, 32'h44, 5'd0, 32'h33, 5'd4, 32'h22, 5'd6, 9'h101);
        @(negedge clk);
        bus.stall = 1; bus.wb_we = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'hEE;
        @(negedge clk);
        chk("rs1_x0_hold", 64'(bus.ex_rs1_data), 64'h33);
        chk("stall_cnt_3", 64'(stall_count),     64'd3);

        // Dual refresh when rs1 == rs2 == wb_rd
        bus.stall = 0; bus.wb_we = 0;
        set_id(1, 32'h48, 5'd7, 32'h1, 5'd7, 32'h2, 5'd8, 9'h1F0);
        @(negedge clk);
        bus.stall = 1; bus.wb_we = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h55;
        @(negedge clk);
        chk("dual_rs1", 64'(bus.ex_rs1_data), 64'h55);
        chk("dual_rs2", 64'(bus.ex_rs2_data), 64'h55);
        bus.wb_we = 0; bus.wb_data = 32'h66;
        @(negedge clk);
        chk("nowe_rs1", 64'(bus.ex_rs1_data), 64'h55);
        chk("nowe_rs2", 64'(bus.ex_rs2_data), 64'h55);
        chk("stall_cnt_5", 64'(stall_count),  64'd5);

        // Flush during stall
        bus.stall = 0;
        set_id(1, 32'h4C, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd5, 9'h1FF);
        @(negedge clk);
        chk("pre_flush_rd", 64'(bus.ex_rd), 64'd5);
        bus.flush = 1; bus.stall = 1;
        @(negedge clk);
        chk("flush_valid",  64'(bus.ex_valid), 64'd0);
        chk("flush_ctrl",   64'(bus.ex_ctrl),  64'd0);
        chk("flush_rd",     64'(bus.ex_rd),    64'd0);
        chk("flush_rs1",    64'(bus.ex_rs1),   64'd0);
        chk("flush_rs2",    64'(bus.ex_rs2),   64'd0);
        chk("flush_bubbles",64'(bubble_count), 64'd1);
        chk("flush_stalls", 64'(stall_count),  64'd5);

        // Stall saturation
        bus.flush = 0; bus.stall = 1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("stall_sat", 64'(stall_count), 64'd15);

        // Async reset while stalled on a valid instruction
        bus.stall = 0;
        set_id(1, 32'h50, 5'd2, 32'h7, 5'd3, 32'h8, 5'd4, 9'h003);
        @(negedge clk);
        bus.stall = 1;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.ex_valid), 64'd1);
        #2 rst = 1;
        #1;
        chk("async_valid",  64'(bus.ex_valid),    64'd0);
        chk("async_pc",     64'(bus.ex_pc),       64'd0);
        chk("async_data",   64'(bus.ex_rs1_data), 64'd0);
        chk("async_stalls", 64'(stall_count),     64'd0);
        chk("async_bubbles",64'(bubble_count),    64'd0);
        @(negedge clk);
        rst = 0; bus.stall = 0; bus.id_valid = 0;
        @(negedge clk);
        chk("idle_bubble_cnt", 64'(bubble_count), 64'd1);
        chk("idle_valid",      64'(bus.ex_valid), 64'd0);
        @(negedge clk);
        chk("idle_bubble_cnt2", 64'(bubble_count), 64'd2);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the RISC-V pipeline. It captures decoded operands, register indices and control bits at the end of ID, and presents them to EX. EX consumes ex_rs1/ex_rs2 for MEM/WB forwarding comparison. Supports stall (hold), flush (bubble insert) and refresh of held operands from write-back, and keeps saturating stall/bubble counters for performance debug.

Parameters:
XLEN, 32, datapath/PC width
CTRL_W, 9, control bundle width (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, ALUOp[1:0])
CNT_W, 16, width of the stall and bubble counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold current contents (from hazard detection)
flush  in  1  replace contents with bubble (branch/jump taken)
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_funct3  in  3  funct3
id_funct7b5  in  1  funct7[5]
id_ctrl  in  CTRL_W  control bundle
wb_we  in  1  write-back RegWrite
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back value
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  out  5  registered indices
ex_funct3  out  3; ex_funct7b5  out  1; ex_ctrl  out  CTRL_W
stall_count  out  CNT_W  cycles spent stalled
bubble_count  out  CNT_W  bubbles loaded into EX

Behaviour:
- Reset: all outputs 0, including both counters. Reset is asynchronous, so outputs go to 0 immediately on rst=1, independent of clk.
- Latency: one cycle. Inputs sampled on edge N appear on the outputs after edge N.
- Per-edge priority: rst > flush > stall > load.
- Flush: ex_valid=0, ex_ctrl=0, ex_rd=ex_rs1=ex_rs2=0. All data fields are set to 0. A flush during a stall wins, and the stall is not counted.
- Stall (flush=0): every field holds, with one exception, the refresh rule.
  - Refresh rule: if wb_we and wb_rd!=0 and ex_valid and wb_rd==ex_rs1, then ex_rs1_data <= wb_data. The same rule applies independently for rs2.
  - Both fields refresh when ex_rs1==ex_rs2==wb_rd.
  - Purpose: the held operand does not go stale once the producer leaves MEM/WB.
- Load (no stall, no flush):
  - id_valid=1: capture all id_* fields, ex_valid=1.
  - id_valid=0: load a bubble, with the same field values as flush.
- No refresh is performed on load. The register file handles the WB/ID same-cycle write-first case.
- Index x0 is never refreshed.
- stall_count: +1 on each edge with stall=1 and flush=0 and rst=0. It saturates at all-ones and never wraps.
- bubble_count: +1 on each edge that loads a bubble (flush=1, or a load with id_valid=0). It saturates at all-ones.
- Both counters may increment on the same edge? No. The stall and bubble conditions are mutually exclusive by the priority rule.
- rst asserted mid-stall or mid-flush: the register clears immediately. The first edge after deassertion is a normal edge.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - XLEN
  - CTRL_W
  - bit-position constants for each ctrl field (CTRL_REGWRITE, CTRL_MEMREAD, ...)
  - CTRL_NOP = all zeros
  - REG_X0 = 5'd0
- One natural sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count). It is instantiated twice.

Test Plan:
- Reset then load: rst pulse, then id_valid=1, id_pc=0x40, id_rd=5, id_ctrl=9'h1FF → one edge later ex_pc=0x40, ex_rd=5, ex_ctrl=0x1FF, ex_valid=1; before the edge all outputs are 0.
- Flush: register holding rd=5, apply flush=1 with stall=1 → ex_valid=0, ex_ctrl=0, ex_rd=ex_rs1=ex_rs2=0; bubble_count 0→1; stall_count unchanged.
- Stall refresh: hold ex_rs1=3, ex_rs1_data=0x11, stall=1, wb_we=1, wb_rd=3, wb_data=0xAB → ex_rs1_data=0xAB, other fields unchanged, stall_count +1. Repeat with wb_rd=0 and ex_rs1=0 → no change.
- Dual refresh: ex_rs1=ex_rs2=7, stall, wb_rd=7, wb_data=0x55 → both data fields become 0x55. Repeat with wb_we=0 → neither changes.
- Counter saturation: CNT_W=4, hold stall=1 for 20 cycles → stall_count reaches 15 and stays at 15.
- Async reset mid-stall: assert rst between edges while stalled with ex_valid=1 → all outputs 0 before the next edge. Deassert and load id_valid=0 → bubble loaded, bubble_count=1.
